capture_buffer_reader: RTL and testbench
========================================

Name: capture_buffer_reader

Overview:
AXI-style read initiator that drains the capture buffer. On a start pulse it sweeps addresses 0..buffer_length-1, issues one read request per address, and collects each returned signed I/Q pair. Each pair is forwarded on a valid/ready sample stream with a last flag. It sits between the capture buffer's read port and downstream correlation or readout logic.

Parameters:
buffer_length, 10, number of entries to read; addresses 0..buffer_length-1
index_bits, 4, address width; must satisfy 2^index_bits >= buffer_length
i_bits, 12, I sample width (signed)
q_bits, 12, Q sample width (signed)
timeout_cycles, 8, maximum WAIT cycles before abort (only with CAPTURE_READER_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a sweep when idle
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  one-cycle pulse at sweep end (normal or aborted)
error  out  1  sticky timeout flag; cleared by the next accepted start
m_axi_rvalid  out  1  read request valid
m_axi_rready  out  1  read request ready; driven identically to m_axi_rvalid
m_axi_raddr  out  index_bits  read address
s_axi_rvalid  in  1  read data valid from the buffer
i  in  i_bits  signed read data I
q  in  q_bits  signed read data Q
out_i  out  i_bits  signed sample I
out_q  out  q_bits  signed sample Q
out_valid  out  1  sample valid
out_ready  in  1  downstream ready
out_last  out  1  high with the final address's sample

Behaviour:
- Reset: all outputs 0 (busy, done, error, m_axi_*, out_*). State is IDLE and the address counter is 0. Reset mid-sweep aborts immediately, with no done pulse.
- States and transitions:
  - IDLE: start=1 -> REQ, addr=0, error cleared.
  - REQ: one cycle. m_axi_rvalid=m_axi_rready=1 and m_axi_raddr=addr -> WAIT.
  - WAIT: m_axi_* = 0. On s_axi_rvalid=1, register i and q into out_i/out_q, set out_valid=1 and out_last=(addr==buffer_length-1) -> OUT.
  - OUT: hold out_valid, out_i, out_q and out_last stable until out_ready=1. On that handshake, clear out_valid and out_last. If last -> DONE, else addr+1 -> REQ.
  - DONE: done=1 for one cycle, busy=0 next cycle -> IDLE.
- Request handshake is single-beat: the request is asserted for exactly one cycle and at most one request is outstanding.
- Response timing: the buffer returns data 2 cycles after the request cycle. With request in cycle T, s_axi_rvalid arrives in T+2 and out_valid rises in T+3. With out_ready held at 1, throughput is one sample per 4 cycles.
- s_axi_rvalid outside WAIT (stray, or in flight across a reset) is ignored.
- start outside IDLE is ignored. start in the same cycle as DONE is ignored.
- Data is captured unmodified: out_i/out_q widths equal i/q widths, with no sign extension or truncation.
- out_valid never drops without a handshake, except on reset or timeout abort.

Optional Feature:
CAPTURE_READER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without s_axi_rvalid.
  - When the counter reaches timeout_cycles: error=1 (sticky), go to DONE, and pulse done with out_valid=0.
  - No further requests are issued in that sweep.
- Not defined: WAIT blocks indefinitely, error is tied 0, and no counter is synthesized.

Test Plan:
1. Full sweep: buffer entry k={I=k+1, Q=-(k+1)}, start pulse, out_ready=1 -> 10 samples out in order (1,-1)...(10,-10). out_last only on the 10th sample. done pulses once. Requests at addresses 0..9 occur at 4-cycle spacing.
2. Backpressure: out_ready=0 for 5 cycles when the 3rd sample is valid -> out_valid/out_i/out_q held stable. No new request is issued until the handshake. The sweep then completes with 10 samples.
3. start pulsed mid-sweep at address 4 -> ignored; exactly 10 samples and one done.
4. Timeout (macro defined, timeout_cycles=8): slave never asserts s_axi_rvalid -> 8 WAIT cycles, then error=1 and one done pulse, with no out_valid. A following start clears error and a normal sweep succeeds.
5. Reset asserted for one cycle while in WAIT at address 6 -> all outputs 0 next cycle, no done. The late s_axi_rvalid from that request is ignored. A subsequent start reads from address 0.
6. Stray s_axi_rvalid with i=0x7FF pulsed in IDLE and in OUT -> no change to out_i, out_valid or state.

Source files
------------

// File: rtl/capture_buffer_reader_if.sv
// Bus bundle for capture_buffer_reader: read-request channel, returned I/Q data
// and the outgoing sample stream. master = reader side, slave = buffer/sink side.
interface capture_buffer_reader_if #(
  parameter int index_bits = 4,
  parameter int i_bits     = 12,
  parameter int q_bits     = 12
);
  logic                     m_axi_rvalid;
  logic                     m_axi_rready;
  logic [index_bits-1:0]    m_axi_raddr;
  logic                     s_axi_rvalid;
  logic signed [i_bits-1:0] i;
  logic signed [q_bits-1:0] q;
  logic signed [i_bits-1:0] out_i;
  logic signed [q_bits-1:0] out_q;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output m_axi_rvalid, m_axi_rready, m_axi_raddr,
    input  s_axi_rvalid, i, q,
    output out_i, out_q, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  m_axi_rvalid, m_axi_rready, m_axi_raddr,
    output s_axi_rvalid, i, q,
    input  out_i, out_q, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/capture_buffer_reader.sv
// Sweeps the capture buffer 0..buffer_length-1, one outstanding read at a time,
// and forwards each I/Q pair on a valid/ready stream. CAPTURE_READER_TIMEOUT_EN adds a WAIT abort.
module capture_buffer_reader #(
  parameter int buffer_length  = 10,
  parameter int index_bits     = 4,
  parameter int i_bits         = 12,
  parameter int q_bits         = 12,
  parameter int timeout_cycles = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic error,
  capture_buffer_reader_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DONE} state_t;

  localparam logic [index_bits-1:0] LAST_ADDR = index_bits'(buffer_length - 1);

  state_t                   state;
  logic [index_bits-1:0]    addr;
  logic                     req;
  logic [index_bits-1:0]    raddr;
  logic signed [i_bits-1:0] out_i;
  logic signed [q_bits-1:0] out_q;
  logic                     out_valid;
  logic                     out_last;

`ifdef CAPTURE_READER_TIMEOUT_EN
  localparam int TMO_W = $clog2(timeout_cycles + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      req       <= 1'b0;
      raddr     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef CAPTURE_READER_TIMEOUT_EN
      tmo_cnt   <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      req   <= 1'b0;
      raddr <= '0;
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          addr  <= '0;
          req   <= 1'b1;
          busy  <= 1'b1;
`ifdef CAPTURE_READER_TIMEOUT_EN
          error_q <= 1'b0;
`endif
        end
        REQ: begin
          state <= WAIT;
`ifdef CAPTURE_READER_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.s_axi_rvalid) begin
            out_i     <= bus.i;
            out_q     <= bus.q;
            out_valid <= 1'b1;
            out_last  <= (addr == LAST_ADDR);
            state     <= OUT;
          end
`ifdef CAPTURE_READER_TIMEOUT_EN
          // The abort fires on the timeout_cycles-th empty WAIT cycle.
          else if (tmo_cnt == TMO_W'(timeout_cycles - 1)) begin
            error_q <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        OUT: if (bus.out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (out_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            addr  <= addr + 1'b1;
            raddr <= addr + 1'b1;
            req   <= 1'b1;
            state <= REQ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request is a registered single-cycle beat; address reads 0 outside it.
  assign bus.m_axi_rvalid = req;
  assign bus.m_axi_rready = req;
  assign bus.m_axi_raddr  = raddr;
  assign bus.out_i        = out_i;
  assign bus.out_q        = out_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_last     = out_last;

endmodule

// File: tb/tb_capture_buffer_reader.sv
// Directed bench for capture_buffer_reader: 2-cycle latency buffer model with
// entry k = {k+1, -(k+1)}, stream/request/done loggers, one task per scenario.
module tb_capture_buffer_reader;
  localparam int BL = 10;
  localparam int IB = 4;
  localparam int W  = 12;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, error;
  always #5 clk = ~clk;

  capture_buffer_reader_if #(.index_bits(IB), .i_bits(W), .q_bits(W)) bus();

  capture_buffer_reader #(
    .buffer_length(BL), .index_bits(IB), .i_bits(W), .q_bits(W), .timeout_cycles(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error), .bus(bus)
  );

  // Buffer model: data returns two cycles after the request cycle.
  logic p1 = 1'b0, p2 = 1'b0, mute = 1'b0, stray = 1'b0;
  logic [IB-1:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    p1 <= bus.m_axi_rvalid & ~mute;
    a1 <= bus.m_axi_raddr;
    p2 <= p1;
    a2 <= a1;
  end
  assign bus.s_axi_rvalid = p2 | stray;
  assign bus.i = stray ? 12'h7FF : W'(int'(a2) + 1);
  assign bus.q = stray ? 12'h7FF : W'(-(int'(a2) + 1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [24:0] smp[$];
  int req_a[$];
  int req_c[$];
  int done_cnt = 0, vld_cnt = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) smp.push_back({bus.out_last, bus.out_i, bus.out_q});
    if (bus.m_axi_rvalid) begin req_a.push_back(int'(bus.m_axi_raddr)); req_c.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (bus.out_valid) vld_cnt++;
  end

  int pass_cnt = 0, tot_cnt = 0;

  task automatic clear_logs();
    smp.delete(); req_a.delete(); req_c.delete();
    done_cnt = 0; vld_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin @(posedge clk); n++; end
    ok = (done_cnt != 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if ({busy, done, error} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {busy, done, error});
    else pass_cnt++;
    tot_cnt++;
    if ({bus.m_axi_rvalid, bus.m_axi_rready, bus.m_axi_raddr} !== 6'h0)
      $display("FAIL reset_req got=%h want=0", {bus.m_axi_rvalid, bus.m_axi_rready, bus.m_axi_raddr});
    else pass_cnt++;
    tot_cnt++;
    if ({bus.out_valid, bus.out_last, bus.out_i, bus.out_q} !== 26'h0)
      $display("FAIL reset_stream got=%h want=0", {bus.out_valid, bus.out_last, bus.out_i, bus.out_q});
    else pass_cnt++;
  endtask

  task automatic test_full_sweep();
    bit ok;
    clear_logs();
    bus.out_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    tot_cnt++;
    if ({busy, bus.m_axi_rvalid, bus.m_axi_rready, bus.m_axi_raddr} !== 7'b111_0000)
      $display("FAIL sweep_first_req got=%b want=1110000", {busy, bus.m_axi_rvalid, bus.m_axi_rready, bus.m_axi_raddr});
    else pass_cnt++;
    wait_done(ok);
    tot_cnt++;
    if (!ok) $display("FAIL sweep_done_timeout got=0 want=1"); else pass_cnt++;
    for (int k = 0; k < BL; k++) begin
      logic [24:0] got = (k < smp.size()) ? smp[k] : 'x;
      logic [24:0] exp = {k == BL - 1, W'(k + 1), W'(-(k + 1))};
      tot_cnt++;
      if (got !== exp) $display("FAIL sweep_sample[%0d] got=%h want=%h", k, got, exp); else pass_cnt++;
    end
    for (int k = 0; k < BL; k++) begin
      int got = (k < req_a.size()) ? req_a[k] : -1;
      tot_cnt++;
      if (got != k) $display("FAIL sweep_req_addr[%0d] got=%0d want=%0d", k, got, k); else pass_cnt++;
    end
    for (int k = 1; k < BL; k++) begin
      int got = (k < req_c.size()) ? req_c[k] - req_c[k-1] : -1;
      tot_cnt++;
      if (got != 4) $display("FAIL sweep_req_spacing[%0d] got=%0d want=4", k, got); else pass_cnt++;
    end
    tot_cnt++;
    if (smp.size() != BL || done_cnt != 1)
      $display("FAIL sweep_counts got=%0d/%0d want=10/1", smp.size(), done_cnt);
    else pass_cnt++;
    tot_cnt++;
    if ({busy, error, bus.out_valid} !== 3'b000) $display("FAIL sweep_idle got=%b want=000", {busy, error, bus.out_valid});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int n = 0, nreq;
    clear_logs();
    bus.out_ready = 1'b1;
    pulse_start();
    while (smp.size() < 2 && n < 100) begin @(posedge clk); n++; end
    #1 bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    nreq = req_a.size();
    repeat (5) begin
      @(negedge clk);
      tot_cnt++;
      if ({bus.out_valid, bus.out_i, bus.out_q} !== {1'b1, 12'd3, 12'hFFD})
        $display("FAIL bp_hold got=%h want=%h", {bus.out_valid, bus.out_i, bus.out_q}, {1'b1, 12'd3, 12'hFFD});
      else pass_cnt++;
      tot_cnt++;
      if (req_a.size() != nreq || nreq != 3) $display("FAIL bp_no_req got=%0d want=3", req_a.size());
      else pass_cnt++;
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_done(ok);
    tot_cnt++;
    if (!ok || smp.size() != BL || done_cnt != 1)
      $display("FAIL bp_complete got=%0d/%0d want=10/1", smp.size(), done_cnt);
    else pass_cnt++;
    for (int k = 0; k < BL; k++) begin
      logic [24:0] got = (k < smp.size()) ? smp[k] : 'x;
      logic [24:0] exp = {k == BL - 1, W'(k + 1), W'(-(k + 1))};
      tot_cnt++;
      if (got !== exp) $display("FAIL bp_sample[%0d] got=%h want=%h", k, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int n = 0;
    clear_logs();
    bus.out_ready = 1'b1;
    pulse_start();
    while (req_a.size() < 5 && n < 100) begin @(posedge clk); n++; end
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(ok);
    repeat (20) @(negedge clk);
    tot_cnt++;
    if (!ok || smp.size() != BL || done_cnt != 1 || req_a.size() != BL)
      $display("FAIL midstart_counts got=%0d/%0d/%0d want=10/1/10", smp.size(), done_cnt, req_a.size());
    else pass_cnt++;
    for (int k = 0; k < BL; k++) begin
      logic [24:0] got = (k < smp.size()) ? smp[k] : 'x;
      logic [24:0] exp = {k == BL - 1, W'(k + 1), W'(-(k + 1))};
      tot_cnt++;
      if (got !== exp) $display("FAIL midstart_sample[%0d] got=%h want=%h", k, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    mute = 1'b1;
    bus.out_ready = 1'b1;
    pulse_start();
`ifdef CAPTURE_READER_TIMEOUT_EN
    wait_done(ok);
    tot_cnt++;
    if (!ok || req_a.size() != 1 || done_cyc - req_c[0] != 9)
      $display("FAIL tmo_timing got=%0d want=9", ok ? done_cyc - req_c[0] : -1);
    else pass_cnt++;
    repeat (10) @(negedge clk);
    tot_cnt++;
    if ({error, busy} !== 2'b10 || vld_cnt != 0 || done_cnt != 1 || req_a.size() != 1)
      $display("FAIL tmo_state got=%b/%0d/%0d want=10/0/1", {error, busy}, vld_cnt, done_cnt);
    else pass_cnt++;
    mute = 1'b0;
    clear_logs();
    pulse_start();
    @(negedge clk);
    tot_cnt++;
    if (error !== 1'b0) $display("FAIL tmo_error_clear got=%b want=0", error); else pass_cnt++;
    wait_done(ok);
    tot_cnt++;
    if (!ok || smp.size() != BL || error !== 1'b0)
      $display("FAIL tmo_recover got=%0d/%b want=10/0", smp.size(), error);
    else pass_cnt++;
`else
    // Without the timeout the reader parks in WAIT until reset.
    repeat (25) @(negedge clk);
    tot_cnt++;
    if ({busy, error} !== 2'b10 || done_cnt != 0 || vld_cnt != 0 || req_a.size() != 1)
      $display("FAIL wait_block got=%b/%0d/%0d want=10/0/0", {busy, error}, done_cnt, vld_cnt);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mute = 1'b0;
    clear_logs();
    pulse_start();
    wait_done(ok);
    tot_cnt++;
    if (!ok || smp.size() != BL || done_cnt != 1)
      $display("FAIL wait_recover got=%0d/%0d want=10/1", smp.size(), done_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    clear_logs();
    bus.out_ready = 1'b1;
    pulse_start();
    while (req_a.size() < 7 && n < 100) begin @(posedge clk); n++; end
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if ({busy, done, error, bus.m_axi_rvalid, bus.m_axi_rready, bus.m_axi_raddr} !== 9'h0)
      $display("FAIL rstmid_ctrl got=%b want=0", {busy, done, error, bus.m_axi_rvalid, bus.m_axi_rready, bus.m_axi_raddr});
    else pass_cnt++;
    tot_cnt++;
    if ({bus.out_valid, bus.out_last, bus.out_i, bus.out_q} !== 26'h0)
      $display("FAIL rstmid_stream got=%h want=0", {bus.out_valid, bus.out_last, bus.out_i, bus.out_q});
    else pass_cnt++;
    clear_logs();
    repeat (6) @(negedge clk);
    tot_cnt++;
    if (vld_cnt != 0 || done_cnt != 0 || busy !== 1'b0)
      $display("FAIL rstmid_late_rvalid got=%0d/%0d want=0/0", vld_cnt, done_cnt);
    else pass_cnt++;
    pulse_start();
    wait_done(ok);
    tot_cnt++;
    if (!ok || req_a.size() == 0 || req_a[0] != 0 || smp.size() != BL)
      $display("FAIL rstmid_restart got=%0d want=10", smp.size());
    else pass_cnt++;
  endtask

  task automatic test_stray();
    bit ok;
    int n = 0;
    clear_logs();
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    repeat (3) @(negedge clk);
    tot_cnt++;
    if ({bus.out_valid, busy, bus.out_i} !== {1'b0, 1'b0, 12'd10} || req_a.size() != 0)
      $display("FAIL stray_idle got=%h want=%h", {bus.out_valid, busy, bus.out_i}, {1'b0, 1'b0, 12'd10});
    else pass_cnt++;
    bus.out_ready = 1'b0;
    pulse_start();
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    repeat (3) @(negedge clk);
    tot_cnt++;
    if ({bus.out_valid, bus.out_i, bus.out_q} !== {1'b1, 12'd1, 12'hFFF} || req_a.size() != 1)
      $display("FAIL stray_out got=%h want=%h", {bus.out_valid, bus.out_i, bus.out_q}, {1'b1, 12'd1, 12'hFFF});
    else pass_cnt++;
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_done(ok);
    tot_cnt++;
    if (!ok || smp.size() != BL || smp[0] !== {1'b0, 12'd1, 12'hFFF})
      $display("FAIL stray_complete got=%0d want=10", smp.size());
    else pass_cnt++;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_start_ignored();
    test_timeout();
    test_reset_mid();
    test_stray();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule
